// File: rtl/calc_pkg.sv
// Shared converter types and BCD constants.
package calc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_e;

  localparam logic [3:0] BCD_BLANK      = 4'hF;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/result_bcd_converter_if.sv
// Load/result bus between the calculator result port and the BCD converter.
interface result_bcd_converter_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 5
) ();

  logic                  start_i;
  logic [2*WIDTH-1:0]    bin_i;
  logic [4*DIGITS-1:0]   bcd_o;
  logic                  busy_o;
  logic                  valid_o;

  modport master (output start_i, bin_i, input bcd_o, busy_o, valid_o);
  modport slave  (input start_i, bin_i, output bcd_o, busy_o, valid_o);

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: a digit of 5 or more gets 3 added (4-bit wrap).
module bcd_digit_adj
  import calc_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= BCD_ADJ_THRESH) ? (i_digit + BCD_ADJ_ADD) : i_digit;

endmodule

// File: rtl/result_bcd_converter.sv
// Iterative binary-to-packed-BCD converter, one shift per clock.
// Optional leading-zero blanking when BCD_BLANK_EN is defined.
module result_bcd_converter
  import calc_pkg::*;
#(
  parameter int unsigned width  = 8,
  parameter int unsigned DIGITS = 5
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  result_bcd_converter_if.slave  bus
);

  localparam int unsigned BW   = 2 * width;
  localparam int unsigned BCDW = 4 * DIGITS;
  localparam int unsigned CW   = $clog2(BW + 1);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_SHIFT = ST_SHIFT;
  localparam logic [1:0] S_DONE  = ST_DONE;

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [BW-1:0]        r_bin;
  logic [BCDW-1:0]      r_scratch;
  logic [CW-1:0]        r_cnt;
  logic [BCDW-1:0]      r_bcd;
  logic                 r_valid;
  logic                 r_busy;

  logic [BCDW-1:0]      w_adj;
  logic [BCDW+BW-1:0]   w_shift;
  logic [CW-1:0]        w_cnt_dec;
  logic [BCDW-1:0]      w_final;

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_scratch[4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

  assign w_shift   = {w_adj, r_bin} << 1;
  assign w_cnt_dec = r_cnt - CW'(1);

`ifdef BCD_BLANK_EN
  logic w_lead;

  // Blank leading zeros from the top digit down; the units digit is always shown.
  always_comb begin
    w_final = r_scratch;
    w_lead  = 1'b1;
    for (int d = int'(DIGITS) - 1; d > 0; d--) begin
      if (w_lead && (r_scratch[4*d +: 4] == 4'd0)) begin
        w_final[4*d +: 4] = BCD_BLANK;
      end else begin
        w_lead = 1'b0;
      end
    end
  end
`else
  assign w_final = r_scratch;
`endif

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start_i)         w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_cnt_dec == '0)     w_state_nxt = S_DONE;
      S_DONE:                           w_state_nxt = S_IDLE;
      default:                          w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: load in IDLE, shift-add in SHIFT, publish in DONE.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_bin     <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_bcd     <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_busy  <= (w_state_nxt != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (bus.start_i) begin
            r_bin     <= bus.bin_i;
            r_scratch <= '0;
            r_cnt     <= CW'(BW);
          end
        end
        S_SHIFT: begin
          r_scratch <= w_shift[BCDW+BW-1:BW];
          r_bin     <= w_shift[BW-1:0];
          r_cnt     <= w_cnt_dec;
        end
        S_DONE: begin
          r_bcd   <= w_final;
          r_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.bcd_o   = r_bcd;
  assign bus.busy_o  = r_busy;
  assign bus.valid_o = r_valid;

endmodule

// File: tb/tb_result_bcd_converter.sv
// Self-checking bench for result_bcd_converter (width=8/DIGITS=5 and width=4/DIGITS=3).
module tb_result_bcd_converter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  result_bcd_converter_if #(.WIDTH(8), .DIGITS(5)) if8 ();
  result_bcd_converter_if #(.WIDTH(4), .DIGITS(3)) if4 ();

  result_bcd_converter #(.width(8), .DIGITS(5)) u_dut8 (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (if8)
  );

  result_bcd_converter #(.width(4), .DIGITS(3)) u_dut4 (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (if4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] bin;
    logic [19:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: decimal digits by division, then the leading-zero rule.
  function automatic logic [19:0] ref_bcd(input int unsigned v, input int unsigned nd);
    logic [19:0] r;
    int unsigned p;
    bit lead;
    r = '0;
    p = 1;
    for (int d = 0; d < int'(nd); d++) begin
      r[4*d +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
`ifdef BCD_BLANK_EN
    lead = 1'b1;
    for (int d = int'(nd) - 1; d > 0; d--) begin
      if (lead && r[4*d +: 4] == 4'd0) r[4*d +: 4] = 4'hF;
      else lead = 1'b0;
    end
`else
    lead = 1'b0;
`endif
    return r;
  endfunction

  // Run one conversion starting at posedge+1; returns at posedge+1 after the valid pulse.
  task automatic run_conv(input bit sel4, input logic [15:0] v, input logic [19:0] exp,
                          input string name, input bit disturb);
    int lat;
    int exp_lat;
    logic vld;
    logic [19:0] bcd;
    exp_lat = sel4 ? 9 : 17;
    if (sel4) begin if4.start_i = 1'b1; if4.bin_i = v[7:0]; end
    else      begin if8.start_i = 1'b1; if8.bin_i = v;      end
    @(posedge clk); #1;
    if4.start_i = 1'b0;
    if8.start_i = 1'b0;
    chk({name, " busy_after_start"}, 32'(sel4 ? if4.busy_o : if8.busy_o), 32'd1);
    lat = 0;
    vld = 1'b0;
    while (!vld && lat < 40) begin
      if (!sel4) begin
        if8.start_i = disturb && (lat == 5 || lat == 16);
        if8.bin_i   = 16'd9;
      end
      @(posedge clk); #1;
      lat++;
      vld = sel4 ? if4.valid_o : if8.valid_o;
      if (!vld && lat == exp_lat - 1)
        chk({name, " busy_in_done"}, 32'(sel4 ? if4.busy_o : if8.busy_o), 32'd1);
    end
    if8.start_i = 1'b0;
    if (!vld) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s timeout: no valid_o within %0d cycles", name, lat);
      return;
    end
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    bcd = sel4 ? {8'h00, if4.bcd_o} : if8.bcd_o;
    chk({name, " bcd"}, 32'(bcd), 32'(exp));
    @(posedge clk); #1;
    chk({name, " valid_one_pulse"}, 32'(sel4 ? if4.valid_o : if8.valid_o), 32'd0);
    chk({name, " idle_after"}, 32'(sel4 ? if4.busy_o : if8.busy_o), 32'd0);
  endtask

  vec_t tbl[6];
  int   seen_valid;
  logic [15:0] rv;

  initial begin
    n_checks = 0;
    n_errors = 0;
    if8.start_i = 1'b0; if8.bin_i = '0;
    if4.start_i = 1'b0; if4.bin_i = '0;

`ifdef BCD_BLANK_EN
    tbl[0] = '{16'd255,   20'hFF255};
    tbl[1] = '{16'hFFFF,  20'h65535};
    tbl[2] = '{16'd0,     20'hFFFF0};
    tbl[3] = '{16'd1234,  20'hF1234};
    tbl[4] = '{16'd10000, 20'h10000};
    tbl[5] = '{16'd100,   20'hFF100};
`else
    tbl[0] = '{16'd255,   20'h00255};
    tbl[1] = '{16'hFFFF,  20'h65535};
    tbl[2] = '{16'd0,     20'h00000};
    tbl[3] = '{16'd1234,  20'h01234};
    tbl[4] = '{16'd10000, 20'h10000};
    tbl[5] = '{16'd100,   20'h00100};
`endif

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset bcd",   32'(if8.bcd_o),   32'd0);
    chk("reset busy",  32'(if8.busy_o),  32'd0);
    chk("reset valid", 32'(if8.valid_o), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("post_reset bcd",   32'(if8.bcd_o),   32'd0);
    chk("post_reset busy",  32'(if8.busy_o),  32'd0);
    chk("post_reset valid", 32'(if8.valid_o), 32'd0);

    foreach (tbl[i]) run_conv(1'b0, tbl[i].bin, tbl[i].exp, $sformatf("vec%0d", i), 1'b0);

    // Starts during SHIFT and DONE are ignored; the cycle after valid_o is accepted.
`ifdef BCD_BLANK_EN
    run_conv(1'b0, 16'd255, 20'hFF255, "ignore_busy", 1'b1);
    run_conv(1'b0, 16'd9,   20'hFFFF9, "back_to_back", 1'b0);
`else
    run_conv(1'b0, 16'd255, 20'h00255, "ignore_busy", 1'b1);
    run_conv(1'b0, 16'd9,   20'h00009, "back_to_back", 1'b0);
`endif

    // Asynchronous reset in the middle of a conversion.
    if8.start_i = 1'b1; if8.bin_i = 16'd1234;
    @(posedge clk); #1;
    if8.start_i = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst bcd",   32'(if8.bcd_o),   32'd0);
    chk("async_rst busy",  32'(if8.busy_o),  32'd0);
    chk("async_rst valid", 32'(if8.valid_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen_valid = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (if8.valid_o) seen_valid++;
    end
    chk("async_rst no_valid", 32'(seen_valid), 32'd0);
    chk("async_rst bcd_held", 32'(if8.bcd_o), 32'd0);
`ifdef BCD_BLANK_EN
    run_conv(1'b0, 16'd1234, 20'hF1234, "after_rst", 1'b0);
`else
    run_conv(1'b0, 16'd1234, 20'h01234, "after_rst", 1'b0);
`endif

    run_conv(1'b1, 16'd200, 20'h00200, "w4_200", 1'b0);

    for (int i = 0; i < 20; i++) begin
      rv = 16'($urandom_range(0, 65535));
      run_conv(1'b0, rv, ref_bcd(int'(rv), 5), $sformatf("rnd8_%0d", rv), 1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      rv = 16'($urandom_range(0, 255));
      run_conv(1'b1, rv, ref_bcd(int'(rv), 3), $sformatf("rnd4_%0d", rv), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
